// File: rtl/bcd_seq_converter_pkg.sv
`default_nettype none
// ============================================================
// Package  : bcd_pkg
// Desc     : Shared types and constants for the BCD converter
// Revision : 1.0
// ============================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_VALUE     = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_seq_converter_if.sv
`default_nettype none
// ============================================================
// Interface: bcd_seq_converter_if
// Desc     : start/done handshake and result bus of the converter
// Revision : 1.0
// ============================================================
interface bcd_seq_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, valid, bcd, ovf, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, valid, bcd, ovf, blank
    );
endinterface
`default_nettype wire

// File: rtl/bcd_seq_converter_digit_adj.sv
`default_nettype none
// ============================================================
// Module   : bcd_digit_adj
// Desc     : One BCD digit "if >= 5 then add 3" correction cell
// Revision : 1.0
// ============================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Input never exceeds 9, so the 4-bit sum cannot wrap.
    assign o_digit = (i_digit >= ADJ_THRESHOLD) ? (i_digit + ADJ_VALUE) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================
// Module   : bcd_seq_converter
// Desc     : Sequential double-dabble binary-to-BCD converter
// Revision : 1.0
// ============================================================
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                 clk,
    input  logic                 reset,
    bcd_seq_converter_if.slave   bus
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_bcd_w = 4 * DIGITS;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_bcd_w-1:0]   r_scratch;
    logic                 r_ovf_sticky;
    logic [c_cnt_w-1:0]   r_count;

    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf;
    logic [DIGITS-1:0]    r_blank;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_next_scratch;
    logic [WIDTH-1:0]     w_next_shift;
    logic                 w_carry;
    logic                 w_next_ovf;
    logic [DIGITS-1:0]    w_blank;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*gi +: 4]),
            .o_digit (w_adj[4*gi +: 4])
        );
    end

    // One double-dabble step: adjusted digits and operand shift left as one word.
    assign {w_carry, w_next_scratch, w_next_shift} = {w_adj, r_shift, 1'b0};
    assign w_next_ovf = r_ovf_sticky | w_carry;

    always_comb begin : blank_calc
        logic v_hi_zero;
        w_blank   = '0;
        v_hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_hi_zero  = v_hi_zero & (w_next_scratch[4*i +: 4] == 4'd0);
            w_blank[i] = v_hi_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_scratch    <= '0;
            r_ovf_sticky <= 1'b0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_blank      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift      <= bus.bin;
                        r_scratch    <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_count      <= c_cnt_w'(WIDTH);
                        r_busy       <= 1'b1;
                        r_state      <= CONV;
                    end
                end
                CONV: begin
                    r_shift      <= w_next_shift;
                    r_scratch    <= w_next_scratch;
                    r_ovf_sticky <= w_next_ovf;
                    r_count      <= r_count - c_cnt_w'(1);
                    if (r_count == c_cnt_w'(1)) begin
                        r_bcd   <= w_next_scratch;
                        r_ovf   <= w_next_ovf;
                        r_blank <= w_blank;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.valid = r_valid;
    assign bus.bcd   = r_bcd;
    assign bus.ovf   = r_ovf;
    assign bus.blank = r_blank;

endmodule
`default_nettype wire
